vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Raster timing source for the display path; sits directly upstream of the full-screen and sprite renderers.
- Produces the scan position DrawX/DrawY, the display-enable blank (1 = visible pixel), and active-low sync pulses hs/vs.
- Produces one-cycle line_start/frame_start strobes and a frame counter for screen-state logic.
- Default timing is 640x480@60 on a 25 MHz vga_clk.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (cycles)
- H_SYNC, 96, hsync width (cycles)
- H_BACK, 48, horizontal back porch (cycles)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_DELAY, 1, pipeline depth applied to hs/vs/blank when VGA_SYNC_DELAY_EN is defined

Ports:
- vga_clk  input  1  pixel clock; all state changes on its rising edge
- reset  input  1  asynchronous, active-high reset
- DrawX  output  10  current horizontal position, 0..H_TOTAL-1
- DrawY  output  10  current vertical position, 0..V_TOTAL-1
- hs  output  1  horizontal sync, active low
- vs  output  1  vertical sync, active low
- blank  output  1  1 when (DrawX,DrawY) is inside the visible area
- sync  output  1  composite sync, tied to 0
- line_start  output  1  one-cycle pulse when DrawX==0
- frame_start  output  1  one-cycle pulse when DrawX==0 and DrawY==0
- frame_count  output  8  completed-frame count, wraps at 255->0

Behaviour:
- Derived constants: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525).
- Reset (asynchronous, takes effect immediately):
  - DrawX=0, DrawY=0, frame_count=0.
  - hs=1, vs=1, blank=0, line_start=0, frame_start=0.
  - Internal run flag cleared.
- Two-state control: IDLE (run=0) and RUN (run=1).
  - First rising edge after reset release: IDLE->RUN. Counters stay at (0,0); outputs now reflect (0,0): blank=1, line_start=1, frame_start=1.
  - The counter does not advance on that edge, so pixel (0,0) is never skipped.
- In RUN, on each rising edge:
  - DrawX increments.
  - At DrawX==H_TOTAL-1, DrawX wraps to 0 and DrawY increments.
  - At DrawY==V_TOTAL-1 together with the DrawX wrap, DrawY wraps to 0 and frame_count increments (mod 256).
- All outputs are registered. hs/vs/blank/strobes are computed from next-state counters, so they are valid in the same cycle as the DrawX/DrawY they describe. There is no combinational path from counters to outputs.
- Decodes (for the current DrawX/DrawY):
  - blank = (DrawX < H_VISIBLE) && (DrawY < V_VISIBLE).
  - hs = 0 iff H_VISIBLE+H_FRONT <= DrawX < H_VISIBLE+H_FRONT+H_SYNC (656..751).
  - vs = 0 iff V_VISIBLE+V_FRONT <= DrawY < V_VISIBLE+V_FRONT+V_SYNC (490..491), for the full line width.
  - line_start = (DrawX==0). frame_start = (DrawX==0 && DrawY==0).
- Frame period is H_TOTAL*V_TOTAL = 420000 cycles. Line period is 800 cycles.
- Reset asserted mid-frame: all outputs return to reset values asynchronously. After release, IDLE->RUN resumes at (0,0) as above.
- Counter widths are 10 bits. H_TOTAL and V_TOTAL must not exceed 1024; the implementation flags this with an elaboration-time check.

Optional Feature:
- Macro: VGA_SYNC_DELAY_EN.
- Defined:
  - hs, vs and blank each pass through a SYNC_DELAY-stage register chain after the decode.
  - This aligns them with downstream renderers that register RGB one cycle after the ROM read.
  - DrawX, DrawY, line_start, frame_start and frame_count are not delayed.
  - Delay stages reset to hs=1, vs=1, blank=0.
- Not defined: no delay stages; alignment is as described in Behaviour.

Test Plan:
- Reset release: reset 1 then 0 -> first edge gives DrawX=0, DrawY=0, blank=1, line_start=1, frame_start=1, hs=1, vs=1; next edge DrawX=1, strobes 0.
- Horizontal timing: run one line -> hs=0 exactly while DrawX=656..751 (96 cycles); blank=0 for DrawX=640..799; line_start period 800 cycles.
- Line/frame wrap: at (799,10) -> next (0,11). At (799,524) -> next (0,0), frame_start=1, frame_count 0->1.
- Vertical timing: run a full frame -> vs=0 for exactly 1600 cycles (DrawY 490..491); frame_start period 420000; blank high count 307200 per frame.
- Reset mid-frame: assert reset at (300,200) -> same instant DrawX=0, DrawY=0, blank=0, frame_count=0. Release -> (0,0) with frame_start=1 on the first edge.
- With VGA_SYNC_DELAY_EN and SYNC_DELAY=1: hs falls when DrawX=657 and rises at DrawX=753; blank falls at DrawX=641; DrawX/DrawY sequence identical to the non-macro build.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Raster timing source: scan position, active-low syncs, visible-area blank, line/frame strobes and frame count.
// Define VGA_SYNC_DELAY_EN to pass hs/vs/blank through SYNC_DELAY extra register stages.
module vga_timing_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int SYNC_DELAY = 1
) (
    input  logic       vga_clk,
    input  logic       reset,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       sync,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    // Decode bounds are 11 bits so a 1024-wide raster still compares correctly.
    localparam logic [10:0] H_VIS_END    = 11'(H_VISIBLE);
    localparam logic [10:0] H_SYNC_START = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] H_SYNC_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] V_VIS_END    = 11'(V_VISIBLE);
    localparam logic [10:0] V_SYNC_START = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] V_SYNC_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    if (H_TOTAL > 1024 || V_TOTAL > 1024 || SYNC_DELAY < 1) begin : g_bad_config
        $error("vga_timing_gen: H_TOTAL/V_TOTAL must be <= 1024 and SYNC_DELAY >= 1");
    end

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t     state_q, state_d;
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic [7:0] fc_q, fc_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       blank_q, blank_d;
    logic       ls_q, ls_d;
    logic       fs_q, fs_d;

    // The IDLE->RUN edge holds the counters so pixel (0,0) gets a full cycle.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        fc_d    = fc_q;
        if (state_q == ST_IDLE) begin
            state_d = ST_RUN;
        end else if (x_q == H_LAST) begin
            x_d = '0;
            if (y_q == V_LAST) begin
                y_d  = '0;
                fc_d = fc_q + 8'd1;
            end else begin
                y_d = y_q + 10'd1;
            end
        end else begin
            x_d = x_q + 10'd1;
        end
    end

    // Decoding the next position lets every output register line up with DrawX/DrawY.
    always_comb begin
        hs_d    = !(({1'b0, x_d} >= H_SYNC_START) && ({1'b0, x_d} < H_SYNC_END));
        vs_d    = !(({1'b0, y_d} >= V_SYNC_START) && ({1'b0, y_d} < V_SYNC_END));
        blank_d = ({1'b0, x_d} < H_VIS_END) && ({1'b0, y_d} < V_VIS_END);
        ls_d    = (x_d == 10'd0);
        fs_d    = (x_d == 10'd0) && (y_d == 10'd0);
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            fc_q    <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            fc_q    <= fc_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            blank_q <= blank_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
        end
    end

`ifdef VGA_SYNC_DELAY_EN
    logic [SYNC_DELAY-1:0] hs_dly_q, hs_dly_d;
    logic [SYNC_DELAY-1:0] vs_dly_q, vs_dly_d;
    logic [SYNC_DELAY-1:0] blank_dly_q, blank_dly_d;

    always_comb begin
        hs_dly_d       = hs_dly_q;
        vs_dly_d       = vs_dly_q;
        blank_dly_d    = blank_dly_q;
        hs_dly_d[0]    = hs_q;
        vs_dly_d[0]    = vs_q;
        blank_dly_d[0] = blank_q;
        for (int i = 1; i < SYNC_DELAY; i++) begin
            hs_dly_d[i]    = hs_dly_q[i-1];
            vs_dly_d[i]    = vs_dly_q[i-1];
            blank_dly_d[i] = blank_dly_q[i-1];
        end
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            hs_dly_q    <= '1;
            vs_dly_q    <= '1;
            blank_dly_q <= '0;
        end else begin
            hs_dly_q    <= hs_dly_d;
            vs_dly_q    <= vs_dly_d;
            blank_dly_q <= blank_dly_d;
        end
    end

    assign hs    = hs_dly_q[SYNC_DELAY-1];
    assign vs    = vs_dly_q[SYNC_DELAY-1];
    assign blank = blank_dly_q[SYNC_DELAY-1];
`else
    assign hs    = hs_q;
    assign vs    = vs_q;
    assign blank = blank_q;
`endif

    assign DrawX       = x_q;
    assign DrawY       = y_q;
    assign sync        = 1'b0;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
    assign frame_count = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance plus a shrunken raster so whole frames fit in a short run.
// Both are scoreboarded every cycle against a position model derived from the cycle count since reset release.
module tb_vga_timing_gen;

    localparam int S_HV = 40, S_HF = 4, S_HS = 8, S_HB = 6;
    localparam int S_VV = 12, S_VF = 2, S_VS = 2, S_VB = 3;
    localparam int S_HT = S_HV + S_HF + S_HS + S_HB;
    localparam int S_VT = S_VV + S_VF + S_VS + S_VB;

    logic       vga_clk = 1'b0;
    logic       reset   = 1'b1;

    logic [9:0] d_x, d_y, s_x, s_y;
    logic       d_hs, d_vs, d_blank, d_sync, d_ls, d_fs;
    logic       s_hs, s_vs, s_blank, s_sync, s_ls, s_fs;
    logic [7:0] d_fc, s_fc;

    int         checks = 0;
    int         errors = 0;
    longint     k_cnt;
    logic       score_on = 1'b0;

    vga_timing_gen dut_dflt (
        .vga_clk(vga_clk), .reset(reset),
        .DrawX(d_x), .DrawY(d_y), .hs(d_hs), .vs(d_vs), .blank(d_blank), .sync(d_sync),
        .line_start(d_ls), .frame_start(d_fs), .frame_count(d_fc)
    );

    vga_timing_gen #(
        .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
        .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB)
    ) dut_small (
        .vga_clk(vga_clk), .reset(reset),
        .DrawX(s_x), .DrawY(s_y), .hs(s_hs), .vs(s_vs), .blank(s_blank), .sync(s_sync),
        .line_start(s_ls), .frame_start(s_fs), .frame_count(s_fc)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Edges since reset release; the model derives everything from this.
    always @(posedge vga_clk or posedge reset) begin
        if (reset) k_cnt <= 0;
        else       k_cnt <= k_cnt + 1;
    end

    function automatic logic [2:0] decode(input int hv, hf, hsw, vv, vf, vsw, input int x, y);
        logic h, v, b;
        h = !(x >= hv + hf && x < hv + hf + hsw);
        v = !(y >= vv + vf && y < vv + vf + vsw);
        b = (x < hv) && (y < vv);
        return {h, v, b};
    endfunction

    function automatic logic [33:0] modelOut(input int hv, hf, hsw, hb, vv, vf, vsw, vb, input longint k);
        int         ht, vt, x, y;
        longint     t;
        logic [7:0] fc;
        logic [2:0] hvb;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        if (k == 0) return {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        t  = k - 1;
        x  = int'(t % ht);
        y  = int'((t / ht) % vt);
        fc = 8'((t / (ht * vt)) % 256);
`ifdef VGA_SYNC_DELAY_EN
        if (k == 1) hvb = 3'b110;
        else        hvb = decode(hv, hf, hsw, vv, vf, vsw, int'((t - 1) % ht), int'(((t - 1) / ht) % vt));
`else
        hvb = decode(hv, hf, hsw, vv, vf, vsw, x, y);
`endif
        return {10'(x), 10'(y), hvb, 1'b0, (x == 0), (x == 0 && y == 0), fc};
    endfunction

    // Full-output scoreboard on the falling edge, away from the active edge.
    always @(negedge vga_clk) begin
        if (score_on) begin
            checkOutput("dflt_sb", 64'({d_x, d_y, d_hs, d_vs, d_blank, d_sync, d_ls, d_fs, d_fc}),
                        64'(modelOut(640, 16, 96, 48, 480, 10, 2, 33, k_cnt)));
            checkOutput("small_sb", 64'({s_x, s_y, s_hs, s_vs, s_blank, s_sync, s_ls, s_fs, s_fc}),
                        64'(modelOut(S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB, k_cnt)));
        end
    end

    task automatic stepEdge();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic applyStimulus(input int run_cycles, input int hold_cycles);
        repeat (run_cycles) @(posedge vga_clk);
        #($urandom_range(1, 9));
        reset = 1'b1;
        repeat (hold_cycles) @(posedge vga_clk);
        #($urandom_range(1, 9));
        reset = 1'b0;
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int       n, hs_low, blank_low, vs_low, blank_high, fc0;
        int       hs_fall, hs_rise, blank_fall;
        logic     prev_hs, prev_blank, found;
        logic     exp_blank0;
        int       hs_fall_exp, hs_rise_exp, blank_fall_exp;

`ifdef VGA_SYNC_DELAY_EN
        exp_blank0 = 1'b0; hs_fall_exp = 657; hs_rise_exp = 753; blank_fall_exp = 641;
`else
        exp_blank0 = 1'b1; hs_fall_exp = 656; hs_rise_exp = 752; blank_fall_exp = 640;
`endif
        score_on = 1'b1;
        #12;
        checkOutput("rst_state", 64'({d_x, d_y, d_hs, d_vs, d_blank, d_ls, d_fs, d_fc}),
                    64'({10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0}));
        @(negedge vga_clk); #1 reset = 1'b0;

        stepEdge();
        checkOutput("first_edge", 64'({d_x, d_y, d_hs, d_vs, d_blank, d_ls, d_fs}),
                    64'({10'd0, 10'd0, 1'b1, 1'b1, exp_blank0, 1'b1, 1'b1}));
        stepEdge();
        checkOutput("second_edge", 64'({d_x, d_ls, d_fs}), 64'({10'd1, 1'b0, 1'b0}));

        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            stepEdge();
            found = d_ls;
        end
        checkOutput("line_wait", 64'(found), 64'(1));
        hs_low = 0; blank_low = 0; hs_fall = -1; hs_rise = -1; blank_fall = -1;
        prev_hs = d_hs; prev_blank = d_blank;
        for (int i = 0; i < 800; i++) begin
            if (!d_hs) hs_low++;
            if (!d_blank) blank_low++;
            if (prev_hs && !d_hs && hs_fall < 0) hs_fall = int'(d_x);
            if (!prev_hs && d_hs && hs_rise < 0) hs_rise = int'(d_x);
            if (prev_blank && !d_blank && blank_fall < 0) blank_fall = int'(d_x);
            prev_hs = d_hs; prev_blank = d_blank;
            stepEdge();
        end
        checkOutput("hs_low_cnt", 64'(hs_low), 64'(96));
        checkOutput("blank_low_cnt", 64'(blank_low), 64'(160));
        checkOutput("hs_fall_x", 64'(hs_fall), 64'(hs_fall_exp));
        checkOutput("hs_rise_x", 64'(hs_rise), 64'(hs_rise_exp));
        checkOutput("blank_fall_x", 64'(blank_fall), 64'(blank_fall_exp));
        checkOutput("line_period", 64'({d_ls, d_x}), 64'({1'b1, 10'd0}));

        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            stepEdge();
            found = s_fs;
        end
        checkOutput("frame_wait", 64'(found), 64'(1));
        fc0 = int'(s_fc);
        n = 0; vs_low = 0; blank_high = 0; found = 1'b0;
        while (n < 5000 && !found) begin
            if (!s_vs) vs_low++;
            if (s_blank) blank_high++;
            stepEdge();
            n++;
            found = s_fs;
        end
        checkOutput("frame_period", 64'(n), 64'(S_HT * S_VT));
        checkOutput("vs_low_cnt", 64'(vs_low), 64'(S_VS * S_HT));
        checkOutput("blank_high_cnt", 64'(blank_high), 64'(S_HV * S_VV));
        checkOutput("fc_inc", 64'(s_fc), 64'(8'(fc0 + 1)));

        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            stepEdge();
            found = (s_x == 10'(S_HT - 1)) && (s_y == 10'(S_VT - 1));
        end
        checkOutput("frame_end_wait", 64'(found), 64'(1));
        fc0 = int'(s_fc);
        stepEdge();
        checkOutput("frame_wrap", 64'({s_x, s_y, s_fs, s_fc}), 64'({10'd0, 10'd0, 1'b1, 8'(fc0 + 1)}));

        found = 1'b0;
        for (int i = 0; i < 20000 && !found; i++) begin
            stepEdge();
            found = (d_x == 10'd799) && (d_y == 10'd10);
        end
        checkOutput("line_end_wait", 64'(found), 64'(1));
        stepEdge();
        checkOutput("line_wrap", 64'({d_x, d_y, d_ls, d_fs}), 64'({10'd0, 10'd11, 1'b1, 1'b0}));

        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            stepEdge();
            found = (d_x == 10'd300) && (d_y == 10'd12);
        end
        checkOutput("mid_frame_wait", 64'(found), 64'(1));
        #2 reset = 1'b1;
        #1;
        checkOutput("async_rst_dflt", 64'({d_x, d_y, d_hs, d_vs, d_blank, d_ls, d_fs, d_fc}),
                    64'({10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0}));
        checkOutput("async_rst_small", 64'({s_x, s_y, s_blank, s_fc}), 64'({10'd0, 10'd0, 1'b0, 8'd0}));
        repeat (2) @(posedge vga_clk);
        @(negedge vga_clk); #1 reset = 1'b0;
        stepEdge();
        checkOutput("rerun_first", 64'({d_x, d_y, d_ls, d_fs}), 64'({10'd0, 10'd0, 1'b1, 1'b1}));

        for (int i = 0; i < 12; i++) begin
            applyStimulus(int'($urandom_range(20, 3000)), int'($urandom_range(1, 3)));
        end
        repeat (1500) @(posedge vga_clk);
        @(negedge vga_clk);
        #1;
        score_on = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
